udp_pkt_gen: RTL and testbench

UDP_PKT_GEN -- requirements
Module: udp_pkt_gen

---
 rtl/udp_pkt_gen.sv | 188 ++++++++++++++++++
 tb/tb_udp_pkt_gen.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_pkt_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// udp_pkt_gen : multi-channel UDP payload generator feeding an Ethernet core
// Rev 1.0
// ---------------------------------------------------------------------------
module udp_pkt_gen #(
   parameter int CH_NUM = 4,
   parameter int LEN_W  = 16,
   parameter int CW     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic [7:0]        const_byte,
   input  logic [LEN_W-1:0]  pay_len,
   input  logic [LEN_W-1:0]  gap_cycles,
   input  logic [CH_NUM-1:0] ch_mask,
   input  logic [15:0]       base_port,
   output logic              cvt_tx,
   input  logic              busy_tx,
   input  logic              dv_tx,
   output logic [7:0]        data_tx,
   output logic [LEN_W-1:0]  data_len_tx,
   output logic [15:0]       dst_port,
   output logic [CW-1:0]     cur_ch,
   output logic [31:0]       pkt_cnt,
   output logic              err_overrun
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             rdy_q;
   logic [CW-1:0]    last_q, last_d;
   logic [CW-1:0]    cur_ch_q, cur_ch_d;
   logic [1:0]       mode_q, mode_d;
   logic [7:0]       const_q, const_d;
   logic [7:0]       pat_q, pat_d;
   logic [7:0]       data_q, data_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] gap_q, gap_d;
   logic [15:0]      port_q, port_d;
   logic [31:0]      pkt_q, pkt_d;
   logic             err_q, err_d;

   logic [CW-1:0]    nxt_ch;
   logic [CW-1:0]    lo_ch;
   logic             found_hi;
   logic [7:0]       pat_nxt;

   function automatic logic [7:0] first_byte(input logic [1:0] m, input logic [7:0] c);
      case (m)
         2'd1:    return 8'h00;
         2'd2:    return 8'hFF;
         default: return c;
      endcase
   endfunction

   // Descending scan so the last hit is the lowest qualifying index.
   always_comb begin
      nxt_ch   = '0;
      lo_ch    = '0;
      found_hi = 1'b0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            lo_ch = CW'(i);
            if (i > int'(last_q)) begin
               nxt_ch   = CW'(i);
               found_hi = 1'b1;
            end
         end
      end
      if (!found_hi) nxt_ch = lo_ch;
   end

   always_comb begin
      case (mode_q)
         2'd1:    pat_nxt = pat_q + 8'd1;
         2'd2:    pat_nxt = {pat_q[6:0], pat_q[7] ^ pat_q[5] ^ pat_q[4] ^ pat_q[3]};
         default: pat_nxt = const_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      cur_ch_d = cur_ch_q;
      mode_d   = mode_q;
      const_d  = const_q;
      pat_d    = pat_q;
      data_d   = data_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      port_d   = port_q;
      pkt_d    = pkt_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (rdy_q && enable && (|ch_mask) && (|pay_len)) begin
               state_d  = S_REQ;
               len_d    = pay_len;
               last_d   = nxt_ch;
               cur_ch_d = nxt_ch;
               port_d   = base_port + 16'(nxt_ch);
               mode_d   = mode;
               const_d  = const_byte;
               pat_d    = first_byte(mode, const_byte);
               data_d   = first_byte(mode, const_byte);
               cnt_d    = '0;
            end
         end
         S_REQ: begin
            if (busy_tx) state_d = S_SEND;
         end
         S_SEND: begin
            if (dv_tx) begin
               if (cnt_q == len_q) begin
                  err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + LEN_W'(1);
                  pat_d = pat_nxt;
                  // Once the last byte is consumed the bus parks at zero.
                  data_d = (cnt_q + LEN_W'(1) == len_q) ? 8'h00 : pat_nxt;
               end
            end
            if (!busy_tx) begin
               state_d = S_GAP;
               gap_d   = gap_cycles;
               pkt_d   = pkt_q + 32'd1;
            end
         end
         default: begin
            if (gap_q <= LEN_W'(1)) state_d = S_IDLE;
            else                    gap_d   = gap_q - LEN_W'(1);
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rdy_q    <= 1'b0;
         last_q   <= CW'(CH_NUM - 1);
         cur_ch_q <= '0;
         mode_q   <= 2'd0;
         const_q  <= 8'h00;
         pat_q    <= 8'h00;
         data_q   <= 8'h00;
         len_q    <= '0;
         cnt_q    <= '0;
         gap_q    <= '0;
         port_q   <= 16'h0000;
         pkt_q    <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rdy_q    <= 1'b1;
         last_q   <= last_d;
         cur_ch_q <= cur_ch_d;
         mode_q   <= mode_d;
         const_q  <= const_d;
         pat_q    <= pat_d;
         data_q   <= data_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         gap_q    <= gap_d;
         port_q   <= port_d;
         pkt_q    <= pkt_d;
         err_q    <= err_d;
      end
   end

   assign cvt_tx      = (state_q == S_REQ);
   assign data_tx     = data_q;
   assign data_len_tx = len_q;
   assign dst_port    = port_q;
   assign cur_ch      = cur_ch_q;
   assign pkt_cnt     = pkt_q;
   assign err_overrun = err_q;

endmodule
`default_nettype wire

// File: tb/tb_udp_pkt_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_udp_pkt_gen : randomized self-checking bench with a packet-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_udp_pkt_gen;

   localparam int CH_NUM = 4;
   localparam int LEN_W  = 16;
   localparam int CW     = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic [1:0]        mode = 2'd0;
   logic [7:0]        const_byte = 8'h00;
   logic [LEN_W-1:0]  pay_len = '0;
   logic [LEN_W-1:0]  gap_cycles = '0;
   logic [CH_NUM-1:0] ch_mask = '0;
   logic [15:0]       base_port = 16'h0000;
   logic              busy_tx = 1'b0;
   logic              dv_tx = 1'b0;
   wire               cvt_tx;
   wire  [7:0]        data_tx;
   wire  [LEN_W-1:0]  data_len_tx;
   wire  [15:0]       dst_port;
   wire  [CW-1:0]     cur_ch;
   wire  [31:0]       pkt_cnt;
   wire               err_overrun;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_cnt = 32'd0;
   int          model_last = CH_NUM - 1;
   int          exp_ch;
   logic [15:0] exp_port;
   logic [1:0]  exp_mode;
   logic [7:0]  exp_const;
   int          exp_len;
   logic [7:0]  got[$];

   udp_pkt_gen #(.CH_NUM(CH_NUM), .LEN_W(LEN_W), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
      .const_byte(const_byte), .pay_len(pay_len), .gap_cycles(gap_cycles),
      .ch_mask(ch_mask), .base_port(base_port), .cvt_tx(cvt_tx),
      .busy_tx(busy_tx), .dv_tx(dv_tx), .data_tx(data_tx),
      .data_len_tx(data_len_tx), .dst_port(dst_port), .cur_ch(cur_ch),
      .pkt_cnt(pkt_cnt), .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], ^(s & 8'hB8)};
   endfunction

   // Byte k of a packet as the core should see it on its k-th dv_tx.
   function automatic logic [7:0] exp_byte(input logic [1:0] m, input logic [7:0] c,
                                           input int len, input int k);
      logic [7:0] s;
      if (k >= len) return 8'h00;
      case (m)
         2'd1: return k[7:0];
         2'd2: begin
            s = 8'hFF;
            for (int j = 0; j < k; j++) s = lfsr_step(s);
            return s;
         end
         default: return c;
      endcase
   endfunction

   function automatic int next_ch(input logic [CH_NUM-1:0] m, input int last);
      for (int i = last + 1; i < CH_NUM; i++) if (m[i]) return i;
      for (int i = 0; i < CH_NUM; i++) if (m[i]) return i;
      return -1;
   endfunction

   // Acts as the Ethernet core for one packet and records the model's expectations.
   task automatic run_pkt(input int ndv, input int bdelay, input bit keep_en,
                          input bit scramble, input bit early_dv);
      int t;
      got.delete();
      t = 0;
      while (cvt_tx !== 1'b1 && t < 100) begin
         step();
         t++;
      end
      checks++;
      if (cvt_tx !== 1'b1) begin
         errors++;
         $display("FAIL cvt_timeout: cvt_tx=%b required 1", cvt_tx);
      end
      exp_ch     = next_ch(ch_mask, model_last);
      model_last = exp_ch;
      exp_port   = base_port + exp_ch[15:0];
      exp_mode   = mode;
      exp_const  = const_byte;
      exp_len    = int'(pay_len);
      if (!keep_en) enable = 1'b0;
      if (scramble) begin
         mode       = 2'($urandom);
         const_byte = 8'($urandom);
         pay_len    = LEN_W'($urandom_range(1, 9));
         base_port  = 16'($urandom);
      end
      repeat (bdelay) begin
         dv_tx = early_dv;
         step();
      end
      dv_tx   = 1'b0;
      busy_tx = 1'b1;
      step();
      for (int k = 0; k < ndv; k++) begin
         repeat ($urandom_range(0, 2)) step();
         dv_tx = 1'b1;
         got.push_back(data_tx);
         step();
         dv_tx = 1'b0;
      end
      repeat ($urandom_range(0, 1)) step();
      busy_tx = 1'b0;
      step();
      exp_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1; mode = 2'd1; const_byte = 8'h5A; pay_len = 4;
      gap_cycles = 2; ch_mask = 4'b0001; base_port = 16'd8080;
      repeat (3) step();
      checks++;
      if ({cvt_tx, data_tx, data_len_tx, dst_port, cur_ch, pkt_cnt, err_overrun} !== '0) begin
         errors++;
         $display("FAIL reset_state: cvt=%b data=%h len=%h port=%h ch=%h cnt=%h err=%b required all zero",
                  cvt_tx, data_tx, data_len_tx, dst_port, cur_ch, pkt_cnt, err_overrun);
      end
      rst_n = 1'b1;
      exp_cnt = 0;
      model_last = CH_NUM - 1;
      step();
      checks++;
      if (cvt_tx !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_edge: cvt_tx=%b required 0", cvt_tx);
      end
      step();
      checks++;
      if (cvt_tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_second_edge: cvt_tx=%b required 1", cvt_tx);
      end
   endtask

   task automatic test_incrementing();
      run_pkt(4, 2, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (got[k] !== k[7:0]) begin
            errors++;
            $display("FAIL incr_byte%0d: got %h required %h", k, got[k], k[7:0]);
         end
      end
      checks++;
      if (dst_port !== 16'd8080 || cur_ch !== 2'd0 || data_len_tx !== 16'd4) begin
         errors++;
         $display("FAIL incr_latch: port=%0d ch=%0d len=%0d required 8080 0 4", dst_port, cur_ch, data_len_tx);
      end
      checks++;
      if (pkt_cnt !== 32'd1) begin
         errors++;
         $display("FAIL incr_pkt_cnt: got %0d required 1", pkt_cnt);
      end
   endtask

   task automatic test_lfsr();
      mode = 2'd2; pay_len = 3; gap_cycles = 1;
      for (int p = 0; p < 2; p++) begin
         enable = 1'b1;
         run_pkt(3, 1, 1'b0, 1'b0, 1'b0);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (got[k] !== exp_byte(2'd2, 8'h00, 3, k)) begin
               errors++;
               $display("FAIL lfsr_p%0d_byte%0d: got %h required %h", p, k, got[k], exp_byte(2'd2, 8'h00, 3, k));
            end
         end
      end
   endtask

   task automatic test_round_robin();
      mode = 2'd0; const_byte = 8'($urandom); pay_len = 1; ch_mask = 4'b1010;
      base_port = 16'($urandom);
      for (int p = 0; p < 3; p++) begin
         enable = 1'b1;
         run_pkt(1, 0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (int'(cur_ch) !== exp_ch || dst_port !== exp_port || got[0] !== exp_const) begin
            errors++;
            $display("FAIL rr_p%0d: ch=%0d port=%h byte=%h required %0d %h %h",
                     p, cur_ch, dst_port, got[0], exp_ch, exp_port, exp_const);
         end
      end
   endtask

   task automatic test_overrun();
      mode = 2'd1; pay_len = 2; enable = 1'b1;
      run_pkt(3, 1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (got[k] !== exp_byte(2'd1, 8'h00, 2, k)) begin
            errors++;
            $display("FAIL ovr_byte%0d: got %h required %h", k, got[k], exp_byte(2'd1, 8'h00, 2, k));
         end
      end
      checks++;
      if (err_overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_flag: got %b required 1", err_overrun);
      end
      enable = 1'b1;
      run_pkt(2, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (err_overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_sticky: got %b required 1", err_overrun);
      end
   endtask

   task automatic test_gap();
      int t;
      int gaps[2];
      gaps[0] = 5;
      gaps[1] = 0;
      mode = 2'd0; pay_len = 2; enable = 1'b1;
      for (int g = 0; g < 2; g++) begin
         gap_cycles = LEN_W'(gaps[g]);
         run_pkt(2, 1, 1'b1, 1'b0, 1'b0);
         t = 0;
         while (cvt_tx !== 1'b1 && t < 50) begin
            step();
            t++;
         end
         checks++;
         if (t !== ((gaps[g] > 1) ? gaps[g] : 1) + 1) begin
            errors++;
            $display("FAIL gap_%0d: cycles to next cvt_tx %0d required %0d",
                     gaps[g], t, ((gaps[g] > 1) ? gaps[g] : 1) + 1);
         end
      end
      run_pkt(2, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (pkt_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL gap_pkt_cnt: got %0d required %0d", pkt_cnt, exp_cnt);
      end
   endtask

   task automatic test_random();
      int ndv;
      for (int p = 0; p < 8; p++) begin
         mode       = 2'($urandom);
         const_byte = 8'($urandom);
         pay_len    = LEN_W'($urandom_range(1, 6));
         ch_mask    = CH_NUM'($urandom_range(1, 15));
         base_port  = 16'($urandom);
         gap_cycles = LEN_W'($urandom_range(0, 3));
         ndv        = $urandom_range(1, int'(pay_len) + 1);
         enable     = 1'b1;
         run_pkt(ndv, $urandom_range(0, 3), 1'b0, 1'b1, 1'($urandom));
         for (int k = 0; k < ndv; k++) begin
            checks++;
            if (got[k] !== exp_byte(exp_mode, exp_const, exp_len, k)) begin
               errors++;
               $display("FAIL rand_p%0d_byte%0d: got %h required %h", p, k, got[k],
                        exp_byte(exp_mode, exp_const, exp_len, k));
            end
         end
         checks++;
         if (int'(cur_ch) !== exp_ch || dst_port !== exp_port || int'(data_len_tx) !== exp_len
             || pkt_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL rand_p%0d_hdr: ch=%0d port=%h len=%0d cnt=%0d required %0d %h %0d %0d",
                     p, cur_ch, dst_port, data_len_tx, pkt_cnt, exp_ch, exp_port, exp_len, exp_cnt);
         end
      end
   endtask

   task automatic test_reset_mid();
      int t;
      mode = 2'd1; pay_len = 5; ch_mask = 4'b1010; base_port = 16'd1000; enable = 1'b1;
      t = 0;
      while (cvt_tx !== 1'b1 && t < 100) begin
         step();
         t++;
      end
      busy_tx = 1'b1;
      step();
      repeat (2) begin
         dv_tx = 1'b1;
         step();
      end
      dv_tx = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cvt_tx, data_tx, data_len_tx, dst_port, cur_ch, pkt_cnt, err_overrun} !== '0) begin
         errors++;
         $display("FAIL reset_mid: cvt=%b data=%h len=%h port=%h ch=%h cnt=%h err=%b required all zero",
                  cvt_tx, data_tx, data_len_tx, dst_port, cur_ch, pkt_cnt, err_overrun);
      end
      busy_tx = 1'b0;
      step();
      rst_n = 1'b1;
      exp_cnt = 0;
      model_last = CH_NUM - 1;
      run_pkt(2, 1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (cur_ch !== 2'd1 || dst_port !== 16'd1001 || got[0] !== 8'h00 || got[1] !== 8'h01
          || pkt_cnt !== 32'd1) begin
         errors++;
         $display("FAIL reset_restart: ch=%0d port=%0d b0=%h b1=%h cnt=%0d required 1 1001 00 01 1",
                  cur_ch, dst_port, got[0], got[1], pkt_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_incrementing();
      test_lfsr();
      test_round_robin();
      test_overrun();
      test_gap();
      test_random();
      test_reset_mid();
      repeat (5) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
